// File: rtl/uart_tx.sv
// UART transmitter: 8N1 / 8E1 / 8O1 framing with a runtime-selectable bit period.
// Inputs are latched when a request is accepted in IDLE, so the frame in flight cannot be disturbed.
module uart_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] P_DATA,
    input  logic       data_valid,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    input  logic [5:0] prescale,
    output logic       TX_OUT,
    output logic       busy
);

    // state  | meaning
    // IDLE   | line high, waiting for data_valid
    // START  | start bit (0)
    // DATA   | data bits, LSB first
    // PARITY | parity bit over latched byte
    // STOP   | stop bit (1), then back to IDLE
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t     state_q;
    logic [7:0] data_q;
    logic       par_en_q;
    logic       par_typ_q;
    logic [5:0] presc_q;
    logic [5:0] cnt_q;
    logic [5:0] cnt_d;
    logic [2:0] idx_q;
    logic [2:0] idx_d;
    logic       tx_q;
    logic       busy_q;
    logic       bit_end;
    logic       par_bit;

    // A latched prescale of 0 wraps the 6-bit counter, giving a 64-cycle bit.
    assign cnt_d   = cnt_q + 6'd1;
    assign bit_end = (cnt_d == presc_q);
    assign idx_d   = idx_q + 3'd1;
    assign par_bit = par_typ_q ? ~^data_q : ^data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            data_q    <= 8'd0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            presc_q   <= 6'd0;
            cnt_q     <= 6'd0;
            idx_q     <= 3'd0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q  <= 6'd0;
                    idx_q  <= 3'd0;
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (data_valid) begin
                        data_q    <= P_DATA;
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                        presc_q   <= prescale;
                        tx_q      <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt_q   <= 6'd0;
                        idx_q   <= 3'd0;
                        tx_q    <= data_q[0];
                        state_q <= DATA;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt_q <= 6'd0;
                        if (idx_q == 3'd7) begin
                            idx_q <= 3'd0;
                            if (par_en_q) begin
                                tx_q    <= par_bit;
                                state_q <= PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= STOP;
                            end
                        end else begin
                            idx_q <= idx_d;
                            tx_q  <= data_q[idx_d];
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        cnt_q   <= 6'd0;
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt_q   <= 6'd0;
                        tx_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    cnt_q   <= 6'd0;
                    idx_q   <= 3'd0;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign TX_OUT = tx_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: requested frames go into a scoreboard; a line monitor decodes
// each frame like a receiver and checks bit timing, data, parity, stop and busy.
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] prescale;
    logic       TX_OUT;
    logic       busy;

    uart_tx dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .prescale   (prescale),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       par_en;
        logic       par_typ;
        int         p;
    } frame_t;

    frame_t sb_q[$];
    int     n_checks    = 0;
    int     n_fail      = 0;
    int     exp_frames  = 0;
    int     frames_done = 0;
    logic   gap_check   = 1'b0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic bitval(input frame_t f, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return f.data[k-1];
        if (k == 9 && f.par_en) return f.par_typ ? ~^f.data : ^f.data;
        return 1'b1;
    endfunction

    // Line monitor / loopback receiver
    frame_t      cur;
    logic        in_frame = 1'b0;
    int          gap = 0;
    int          bitk, cyc, match, busy_cnt, nbits;
    logic [10:0] rx_bits;
    logic [7:0]  rx_data;
    logic        expb;
    logic        par_err;

    always @(negedge clk) begin
        if (rst) begin
            in_frame = 1'b0;
            gap      = 0;
        end else begin
            if (!in_frame) begin
                if (TX_OUT == 1'b0) begin
                    check("sb_has_frame", int'(sb_q.size() != 0), 1);
                    if (sb_q.size() != 0) begin
                        cur = sb_q.pop_front();
                    end else begin
                        cur.data = 8'd0; cur.par_en = 1'b0; cur.par_typ = 1'b0; cur.p = 8;
                    end
                    if (gap_check) check("idle_gap", gap, 1);
                    check("busy_at_start", int'(busy), 1);
                    in_frame = 1'b1;
                    bitk = 0; cyc = 0; match = 0; busy_cnt = 0;
                    rx_bits = '0;
                    nbits = cur.par_en ? 11 : 10;
                end else begin
                    if (gap == 0) check("busy_idle", int'(busy), 0);
                    gap++;
                end
            end
            if (in_frame) begin
                expb = bitval(cur, bitk);
                if (TX_OUT == expb) match++;
                if (busy) busy_cnt++;
                if (cyc == cur.p / 2) rx_bits[bitk] = TX_OUT;
                cyc++;
                if (cyc == cur.p) begin
                    check($sformatf("bit%0d_hold", bitk), match, cur.p);
                    bitk++;
                    cyc   = 0;
                    match = 0;
                    if (bitk == nbits) begin
                        rx_data = rx_bits[8:1];
                        check("start_bit", int'(rx_bits[0]), 0);
                        check("rx_data", int'(rx_data), int'(cur.data));
                        if (cur.par_en) begin
                            par_err = rx_bits[9] != (cur.par_typ ? ~^rx_data : ^rx_data);
                            check("par_err", int'(par_err), 0);
                        end
                        check("stp_err", int'(!rx_bits[nbits-1]), 0);
                        check("busy_cycles", busy_cnt, nbits * cur.p);
                        in_frame = 1'b0;
                        gap      = 0;
                        frames_done++;
                    end
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic pe, input logic pt, input int p);
        frame_t f;
        @(posedge clk); #1;
        P_DATA = d; PAR_EN = pe; PAR_TYP = pt; prescale = 6'(p); data_valid = 1'b1;
        f.data = d; f.par_en = pe; f.par_typ = pt; f.p = p;
        sb_q.push_back(f);
        exp_frames++;
        @(posedge clk); #1;
        data_valid = 1'b0;
    endtask

    initial begin
        frame_t f;
        logic [7:0] d;
        logic pe, pt;
        int p;

        rst = 1'b1; data_valid = 1'b0; P_DATA = 8'd0; PAR_EN = 1'b0; PAR_TYP = 1'b0; prescale = 6'd8;
        cycles(3);
        @(negedge clk);
        check("rst_tx", int'(TX_OUT), 1);
        check("rst_busy", int'(busy), 0);

        // Reset wins over a simultaneous request
        @(posedge clk); #1;
        P_DATA = 8'h81; data_valid = 1'b1;
        cycles(1); #1;
        rst = 1'b0; data_valid = 1'b0;
        cycles(20);
        @(negedge clk);
        check("rst_prio_tx", int'(TX_OUT), 1);
        check("rst_prio_busy", int'(busy), 0);
        check("rst_prio_frames", frames_done, 0);

        // Scenario 1-3
        send(8'hA5, 1'b0, 1'b0, 8);   cycles(83);
        send(8'h03, 1'b1, 1'b1, 16);  cycles(179);
        send(8'h03, 1'b1, 1'b0, 16);  cycles(179);

        // Scenario 4: mid-frame request and input changes are ignored
        send(8'hB4, 1'b0, 1'b0, 32);
        cycles(100); #1;
        P_DATA = 8'h55; prescale = 6'd8; PAR_EN = 1'b1; data_valid = 1'b1;
        cycles(1); #1;
        data_valid = 1'b0; P_DATA = 8'hFF;
        cycles(320);
        check("s4_frames", frames_done, exp_frames);

        // Scenario 5: data_valid held high -> frames every 81 cycles
        @(posedge clk); #1;
        P_DATA = 8'h0F; PAR_EN = 1'b0; PAR_TYP = 1'b0; prescale = 6'd8; data_valid = 1'b1;
        f.data = 8'h0F; f.par_en = 1'b0; f.par_typ = 1'b0; f.p = 8;
        repeat (3) begin
            sb_q.push_back(f);
            exp_frames++;
        end
        cycles(11); #1;
        gap_check = 1'b1;
        cycles(190); #1;
        data_valid = 1'b0;
        cycles(100); #1;
        gap_check = 1'b0;
        check("s5_frames", frames_done, exp_frames);

        // Scenario 6: reset during data bit 3
        send(8'hF0, 1'b0, 1'b0, 8);
        cycles(34); #1;
        rst = 1'b1;
        cycles(1); #1;
        rst = 1'b0;
        exp_frames--;
        @(negedge clk);
        check("s6_tx_after_rst", int'(TX_OUT), 1);
        check("s6_busy_after_rst", int'(busy), 0);
        send(8'hC3, 1'b1, 1'b0, 16);
        cycles(179);
        check("s6_frames", frames_done, exp_frames);

        // Scenario 7: randomized frames
        for (int i = 0; i < 30; i++) begin
            d  = 8'($urandom_range(0, 255));
            pe = 1'($urandom_range(0, 1));
            pt = 1'($urandom_range(0, 1));
            p  = 8 << $urandom_range(0, 2);
            send(d, pe, pt, p);
            cycles((pe ? 11 : 10) * p + 3);
        end

        cycles(5);
        check("sb_empty", sb_q.size(), 0);
        check("frames_total", frames_done, exp_frames);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
